// File: rtl/imm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imm_pkg
// Brief    : Shared immediate-format codes and the stage-1 payload type for
//            the immediate encoder (imm_encode / imm_range_chk).
// Revision : 1.0 - initial release
// ============================================================================
package imm_pkg;

    // ImmSrc format codes; any other code is unsupported
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b111;

    // Item captured by stage 1: raw operands plus the precomputed error flag
    typedef struct packed {
        logic [31:0] imm;
        logic [2:0]  src;
        logic [31:0] base;
        logic        err;
    } s1_payload_t;

endpackage
`default_nettype wire

// File: rtl/imm_encode_if.sv
`default_nettype none
// ============================================================================
// Module   : imm_encode_if
// Brief    : Valid/ready bundle for the immediate encoder. The slave modport
//            is the encoder side, the master modport is the producer/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface imm_encode_if #(
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      ImmOp;
    logic [2:0]       ImmSrc;
    logic [31:0]      BaseInstr;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      Instr;
    logic             ImmErr;
    logic [CNT_W-1:0] ErrCount;

    modport slave (
        input  in_valid, ImmOp, ImmSrc, BaseInstr, out_ready,
        output in_ready, out_valid, Instr, ImmErr, ErrCount
    );

    modport master (
        output in_valid, ImmOp, ImmSrc, BaseInstr, out_ready,
        input  in_ready, out_valid, Instr, ImmErr, ErrCount
    );
endinterface
`default_nettype wire

// File: rtl/imm_range_chk.sv
`default_nettype none
// ============================================================================
// Module   : imm_range_chk
// Brief    : Combinational check that an immediate fits the chosen format
//            (sign-extension range and alignment). Unsupported formats are
//            always flagged.
// Revision : 1.0 - initial release
// ============================================================================
module imm_range_chk
    import imm_pkg::*;
(
    input  logic [31:0] imm,
    input  logic [2:0]  src,
    output logic        err
);

    // A field fits when every bit above its sign bit equals the sign bit
    always_comb begin
        err = 1'b1;
        case (src)
            IMM_I, IMM_S: err = !((&imm[31:11]) || (~|imm[31:11]));
            IMM_B:        err = !((&imm[31:12]) || (~|imm[31:12])) || imm[0];
            IMM_J:        err = !((&imm[31:20]) || (~|imm[31:20])) || imm[0];
            IMM_U:        err = |imm[11:0];
            default:      err = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_encode.sv
`default_nettype none
// ============================================================================
// Module   : imm_encode
// Brief    : Scatters a 32-bit immediate into the instruction bit positions
//            of the selected format (I/S/B/J/U), flags unencodable values
//            and keeps a saturating error count. Two-stage valid/ready pipe.
// Config   : IMM_ERR_DROP_EN - when defined, erroneous items are consumed in
//            stage 1 and never reach the output; ImmErr is then tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module imm_encode
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst,
    imm_encode_if.slave  bus
);

    logic              v1;
    logic              v2;
    s1_payload_t       s1;
    logic              in_err;
    logic              accept;
    logic              s2_load;
    logic              s1_adv;
    logic              load2;
    logic [31:0]       packed_instr;
    logic [31:0]       instr_q;
    logic [CNT_W-1:0]  err_cnt;
    logic              unused_imm0;
`ifndef IMM_ERR_DROP_EN
    logic              err_q;
`endif

    imm_range_chk u_range_chk (
        .imm (bus.ImmOp),
        .src (bus.ImmSrc),
        .err (in_err)
    );

    assign s2_load      = !v2 || bus.out_ready;
    assign s1_adv       = v1 && s2_load;
    assign bus.in_ready = !v1 || s2_load;
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef IMM_ERR_DROP_EN
    // Erroneous items leave stage 1 but are not handed to stage 2
    assign load2 = s1_adv && !s1.err;
`else
    assign load2 = s1_adv;
`endif

    // Stage 1: capture operands together with their range-check result
    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
            s1 <= '0;
        end else if (accept) begin
            v1       <= 1'b1;
            s1.imm   <= bus.ImmOp;
            s1.src   <= bus.ImmSrc;
            s1.base  <= bus.BaseInstr;
            s1.err   <= in_err;
        end else if (s1_adv) begin
            v1 <= 1'b0;
        end
    end

    // Scatter immediate bits over the base word; bits outside the format's
    // immediate field (and unsupported formats) pass BaseInstr through
    always_comb begin
        packed_instr = s1.base;
        case (s1.src)
            IMM_I: packed_instr[31:20] = s1.imm[11:0];
            IMM_S: begin
                packed_instr[31:25] = s1.imm[11:5];
                packed_instr[11:7]  = s1.imm[4:0];
            end
            IMM_B: begin
                packed_instr[31]    = s1.imm[12];
                packed_instr[7]     = s1.imm[11];
                packed_instr[30:25] = s1.imm[10:5];
                packed_instr[11:8]  = s1.imm[4:1];
            end
            IMM_J: begin
                packed_instr[31]    = s1.imm[20];
                packed_instr[19:12] = s1.imm[19:12];
                packed_instr[20]    = s1.imm[11];
                packed_instr[30:21] = s1.imm[10:1];
            end
            IMM_U: packed_instr[31:12] = s1.imm[31:12];
            default: ;
        endcase
    end

    // Bit 0 is implied zero in B/J and never stored in the instruction
    assign unused_imm0 = s1.imm[0];

    // Stage 2: registered outputs, held while downstream stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            v2      <= 1'b0;
            instr_q <= '0;
`ifndef IMM_ERR_DROP_EN
            err_q   <= 1'b0;
`endif
        end else if (s2_load) begin
            v2 <= load2;
            if (load2) begin
                instr_q <= packed_instr;
`ifndef IMM_ERR_DROP_EN
                err_q   <= s1.err;
`endif
            end
        end
    end

    // Count erroneous items as they leave stage 1, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (s1_adv && s1.err && !(&err_cnt)) begin
            err_cnt <= err_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.out_valid = v2;
    assign bus.Instr     = instr_q;
    assign bus.ErrCount  = err_cnt;
`ifdef IMM_ERR_DROP_EN
    assign bus.ImmErr    = 1'b0;
`else
    assign bus.ImmErr    = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imm_encode.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_encode
// Brief    : Self-checking bench for imm_encode: directed format cases,
//            backpressure, reset, counter saturation and a randomized run
//            scored against an arithmetic reference model. Honours
//            IMM_ERR_DROP_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_encode;
    import imm_pkg::*;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [31:0] imm;
        logic [2:0]  src;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_encode_if #(.CNT_W(16)) bus  ();
    imm_encode_if #(.CNT_W(2))  bus2 ();

    imm_encode #(.CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bus.slave));
    imm_encode #(.CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bus2.slave));

    int          checks   = 0;
    int          failures = 0;
    exp_t        exp_q[$];
    logic [31:0] out_log[$];
    logic        out_err_log[$];
    int          err_total = 0;
    logic        stalled   = 1'b0;
    logic [31:0] held_instr;
    logic        held_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Encodable ranges expressed as signed intervals plus alignment
    function automatic logic ref_err(input logic [31:0] imm, input logic [2:0] src);
        longint s = longint'($signed(imm));
        case (src)
            3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
            3'd2:       return !(s >= -4096 && s <= 4095 && (imm & 32'h1) == 0);
            3'd3:       return !(s >= -(64'sd1 <<< 20) && s <= (64'sd1 <<< 20) - 1 && (imm & 32'h1) == 0);
            3'd7:       return (imm % 32'd4096) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] ref_instr(input logic [31:0] imm, input logic [2:0] src,
                                              input logic [31:0] b);
        case (src)
            3'd0: return (b & 32'h000F_FFFF) | (imm << 20);
            3'd1: return (b & 32'h01FF_F07F) | (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
            3'd2: return (b & 32'h01FF_F07F) | (((imm >> 12) & 32'h1) << 31) |
                         (((imm >> 5) & 32'h3F) << 25) | (((imm >> 1) & 32'hF) << 8) |
                         (((imm >> 11) & 32'h1) << 7);
            3'd3: return (b & 32'h0000_0FFF) | (((imm >> 20) & 32'h1) << 31) |
                         (((imm >> 1) & 32'h3FF) << 21) | (((imm >> 11) & 32'h1) << 20) |
                         (imm & 32'h000F_F000);
            3'd7: return (b & 32'h0000_0FFF) | (imm & 32'hFFFF_F000);
            default: return b;
        endcase
    endfunction

    // The core's immediate extractor, used for the round-trip property
    function automatic logic [31:0] extract(input logic [31:0] i, input logic [2:0] src);
        case (src)
            3'd0: return {{20{i[31]}}, i[31:20]};
            3'd1: return {{20{i[31]}}, i[31:25], i[11:7]};
            3'd2: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            3'd3: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return {i[31:12], 12'h000};
        endcase
    endfunction

    // One cycle: drive at negedge, sample just after, score the handshakes
    // that the following posedge will perform
    task automatic step(input logic vld, input logic [31:0] imm, input logic [2:0] src,
                        input logic [31:0] base, input logic ordy, output logic took);
        exp_t e;
        logic err;
        @(negedge clk);
        bus.in_valid  = vld;
        bus.ImmOp     = imm;
        bus.ImmSrc    = src;
        bus.BaseInstr = base;
        bus.out_ready = ordy;
        #1;
        took = vld && bus.in_ready;
        if (stalled) begin
            check("hold_valid", 64'(bus.out_valid), 64'd1);
            check("hold_instr", 64'(bus.Instr), 64'(held_instr));
            check("hold_err", 64'(bus.ImmErr), 64'(held_err));
        end
        stalled = 1'b0;
        if (bus.out_valid) begin
            if (ordy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 64'(bus.Instr), 64'hDEAD_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    check("out_instr", 64'(bus.Instr), 64'(e.instr));
                    check("out_err", 64'(bus.ImmErr), 64'(e.err));
                    if (!e.err)
                        check("roundtrip", 64'(extract(bus.Instr, e.src)), 64'(e.imm));
                end
                out_log.push_back(bus.Instr);
                out_err_log.push_back(bus.ImmErr);
            end else begin
                stalled    = 1'b1;
                held_instr = bus.Instr;
                held_err   = bus.ImmErr;
            end
        end
        if (took) begin
            err = ref_err(imm, src);
            if (err) err_total++;
`ifdef IMM_ERR_DROP_EN
            if (!err) exp_q.push_back('{ref_instr(imm, src, base), 1'b0, imm, src});
`else
            exp_q.push_back('{ref_instr(imm, src, base), err, imm, src});
`endif
        end
    endtask

    task automatic push(input logic [31:0] imm, input logic [2:0] src, input logic [31:0] base);
        logic took;
        step(1'b1, imm, src, base, 1'b1, took);
        check("push_accept", 64'(took), 64'd1);
    endtask

    task automatic drain();
        logic took;
        int   n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, took);
            n++;
        end
        for (int k = 0; k < 3; k++) step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, took);
        check("drain_left", 64'(exp_q.size()), 64'd0);
        check("err_count", 64'(bus.ErrCount), 64'((err_total > 65535) ? 65535 : err_total));
    endtask

    initial begin
        logic        took;
        int          nout;
        int          n;
        int          guard;
        logic        pending;
        logic        vld;
        logic [31:0] r, imm, base;
        logic [2:0]  src;
        logic [2:0]  srcs [8];

        srcs = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd7, 3'd4, 3'd5, 3'd6};
        bus.in_valid  = 1'b0; bus.ImmOp = '0; bus.ImmSrc = '0; bus.BaseInstr = '0; bus.out_ready = 1'b1;
        bus2.in_valid = 1'b0; bus2.ImmOp = '0; bus2.ImmSrc = '0; bus2.BaseInstr = '0; bus2.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_instr", 64'(bus.Instr), 64'd0);
        check("rst_imm_err", 64'(bus.ImmErr), 64'd0);
        check("rst_err_count", 64'(bus.ErrCount), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // I-type with two-cycle latency
        push(32'hFFFF_F800, 3'd0, 32'h0000_0013);
        step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, took);
        check("lat_cycle1", 64'(bus.out_valid), 64'd0);
        step(1'b0, 32'h0, 3'd0, 32'h0, 1'b1, took);
        check("lat_cycle2", 64'(bus.out_valid), 64'd1);
        drain();
        check("i_instr", 64'(out_log[out_log.size()-1]), 64'h8000_0013);
        check("i_err", 64'(out_err_log[out_err_log.size()-1]), 64'd0);

        // I-type range error
        nout = out_log.size();
        push(32'h0000_0800, 3'd0, 32'h0000_0013);
        drain();
        check("ierr_count", 64'(bus.ErrCount), 64'd1);
`ifdef IMM_ERR_DROP_EN
        check("ierr_dropped", 64'(out_log.size()), 64'(nout));
`else
        check("ierr_instr", 64'(out_log[out_log.size()-1]), 64'h8000_0013);
        check("ierr_flag", 64'(out_err_log[out_err_log.size()-1]), 64'd1);
`endif

        // B then J back to back
        push(32'hFFFF_FFFC, 3'd2, 32'h0000_0063);
        push(32'h0000_0008, 3'd3, 32'h0000_00EF);
        drain();
        check("b_instr", 64'(out_log[out_log.size()-2]), 64'hFE00_0EE3);
        check("j_instr", 64'(out_log[out_log.size()-1]), 64'h0080_00EF);

        // Misaligned U and unsupported format
        nout = out_log.size();
        push(32'h1234_5001, 3'd7, 32'h0000_0037);
        push(32'h0000_0004, 3'd4, 32'hDEAD_BEEF);
        drain();
`ifdef IMM_ERR_DROP_EN
        check("unsup_dropped", 64'(out_log.size()), 64'(nout));
`else
        check("u_err", 64'(out_err_log[out_err_log.size()-2]), 64'd1);
        check("unsup_instr", 64'(out_log[out_log.size()-1]), 64'hDEAD_BEEF);
        check("unsup_err", 64'(out_err_log[out_err_log.size()-1]), 64'd1);
`endif

        // Backpressure: two items fit, the third waits
        nout = out_log.size();
        step(1'b1, 32'h0000_0011, 3'd0, 32'h0000_0013, 1'b0, took);
        check("bp_acc1", 64'(took), 64'd1);
        step(1'b1, 32'h0000_0022, 3'd1, 32'h0000_0023, 1'b0, took);
        check("bp_acc2", 64'(took), 64'd1);
        step(1'b1, 32'h0000_3000, 3'd7, 32'h0000_0037, 1'b0, took);
        check("bp_acc3_blocked", 64'(took), 64'd0);
        for (int k = 0; k < 3; k++) step(1'b1, 32'h0000_3000, 3'd7, 32'h0000_0037, 1'b0, took);
        check("bp_in_ready", 64'(bus.in_ready), 64'd0);
        n = 0;
        took = 1'b0;
        while (!took && n < 10) begin
            step(1'b1, 32'h0000_3000, 3'd7, 32'h0000_0037, 1'b1, took);
            n++;
        end
        check("bp_acc3", 64'(took), 64'd1);
        drain();
        check("bp_out_count", 64'(out_log.size() - nout), 64'd3);

        // Randomized run with random backpressure
        n = 0; guard = 0; pending = 1'b0; imm = '0; src = '0; base = '0;
        while (n < 300 && guard < 5000) begin
            vld = ($urandom_range(0, 4) != 0);
            if (vld && !pending) begin
                r    = $urandom;
                src  = srcs[$urandom_range(0, 7)];
                base = $urandom;
                case ($urandom_range(0, 3))
                    0: imm = r;
                    1: imm = {{20{r[11]}}, r[11:0]};
                    2: imm = {{12{r[19]}}, r[19:1], 1'b0};
                    default: imm = r & 32'hFFFF_F000;
                endcase
                pending = 1'b1;
            end
            step(vld, imm, src, base, ($urandom_range(0, 9) < 7), took);
            if (took) begin
                pending = 1'b0;
                n++;
            end
            guard++;
        end
        check("random_items", 64'(n), 64'd300);
        drain();

        // Reset with both stages full and ErrCount = 5
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        exp_q.delete(); err_total = 0; stalled = 1'b0;
        for (int k = 0; k < 5; k++) push(32'h0000_0800, 3'd0, 32'h0000_0013);
        drain();
        check("pre_rst_count", 64'(bus.ErrCount), 64'd5);
        step(1'b1, 32'h0000_0001, 3'd0, 32'h0000_0013, 1'b0, took);
        step(1'b1, 32'h0000_0002, 3'd0, 32'h0000_0013, 1'b0, took);
        step(1'b0, 32'h0, 3'd0, 32'h0, 1'b0, took);
        check("pre_rst_out_valid", 64'(bus.out_valid), 64'd1);
        check("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_err_count", 64'(bus.ErrCount), 64'd0);
        check("mid_rst_instr", 64'(bus.Instr), 64'd0);
        @(negedge clk); rst = 1'b0;
        exp_q.delete(); err_total = 0; stalled = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("post_rst_out_valid", 64'(bus.out_valid), 64'd0);

        // Saturation of a 2-bit counter
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus2.in_valid = 1'b1; bus2.ImmOp = 32'h0000_0800; bus2.ImmSrc = 3'd0;
            bus2.BaseInstr = 32'h0000_0013; bus2.out_ready = 1'b1;
        end
        @(negedge clk); bus2.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("sat_count", 64'(bus2.ErrCount), 64'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
